// File: rtl/target_scheduler.sv
// -----------------------------------------------------------------------------
// target_scheduler
//   Picks the next target box, controls how long it stays on screen, detects a
//   hit, and runs the per-game countdown. The one-cycle hit/miss events drive
//   the score and audio logic downstream.
//
//   Build option: DIFFICULTY_RAMP_EN
//     defined   - the show window shrinks by STEP_MS after every hit, and never
//                 drops below MIN_TARGET_MS.
//     undefined - the show window stays at TARGET_MS, and no step logic is built.
//
// Ports
//   CLOCK_50            in   system clock
//   reset               in   asynchronous, active-high
//   start_game          in   one-cycle start request (used in LOBBY/OVER only)
//   lfsr_value[2:0]     in   free-running LFSR, source of the target choice
//   box_address[2:0]    in   Arduino sensor code, asynchronous, 0 = no hit
//   mif_control_signal  out  0 lobby, 1..6 target box, 7 blank/game-over
//   hit_pulse           out  one cycle per valid hit
//   miss_pulse          out  one cycle per expired target
//   seconds_left[5:0]   out  remaining game seconds
//   game_over           out  high while in OVER
// -----------------------------------------------------------------------------
module target_scheduler #(
  parameter int CLK_HZ        = 50000000,
  parameter int GAME_SECONDS  = 60,
  parameter int TARGET_MS     = 1500,
  parameter int MIN_TARGET_MS = 500,
  parameter int STEP_MS       = 100,
  parameter int GAP_MS        = 250
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_game,
  input  logic [2:0] lfsr_value,
  input  logic [2:0] box_address,
  output logic [2:0] mif_control_signal,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [5:0] seconds_left,
  output logic       game_over
);

  localparam int MS_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int MSW    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [MSW-1:0] MS_LAST  = MSW'(MS_DIV - 1);
  localparam logic [9:0]     SEC_LAST = 10'd999;

  // The phase counter has to reach the longest window or gap. The window
  // compare against MIN_TARGET_MS + STEP_MS also has to fit without overflow.
  localparam int WIN_A  = (TARGET_MS > GAP_MS) ? TARGET_MS : GAP_MS;
  localparam int WIN_B  = MIN_TARGET_MS + STEP_MS;
  localparam int CW     = $clog2(((WIN_A > WIN_B) ? WIN_A : WIN_B) + 1);
  localparam logic [CW-1:0] TARGET_W = CW'(TARGET_MS);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_MS - 1);
  localparam logic [5:0]    GAME_S   = 6'(GAME_SECONDS);

  typedef enum logic [1:0] {LOBBY, GAP, SHOW, OVER} state_t;

  state_t         state_reg, state_next;
  logic [MSW-1:0] ms_cnt_reg, ms_cnt_next;
  logic [9:0]     sec_cnt_reg, sec_cnt_next;
  logic [CW-1:0]  phase_reg, phase_next;
  logic [5:0]     seconds_reg, seconds_next;
  logic [2:0]     target_reg, target_next;   // also serves as prev_target
  logic [2:0]     s1_reg, s2_reg, s3_reg;
  logic           hit_req_reg, hit_req_next;
  logic           hit_reg, hit_next;
  logic           miss_reg, miss_next;
  logic           start_ok;
  logic [CW-1:0]  window;

`ifdef DIFFICULTY_RAMP_EN
  localparam logic [CW-1:0] MIN_W   = CW'(MIN_TARGET_MS);
  localparam logic [CW-1:0] STEP_W  = CW'(STEP_MS);
  localparam logic [CW-1:0] FLOOR_W = CW'(MIN_TARGET_MS + STEP_MS);
  logic [CW-1:0] window_reg, window_next;
  assign window = window_reg;
`else
  assign window = TARGET_W;
`endif

  wire ms_tick    = (ms_cnt_reg == MS_LAST);
  wire sec_tick   = ms_tick && (sec_cnt_reg == SEC_LAST);
  // A hit is the arrival of the target code at s2. s3 holds the previous
  // value, so a box held on its code does not fire again.
  wire match_edge = (s2_reg == target_reg) && (s3_reg != target_reg);

  // Clamp the LFSR value into 1..6. Then step past a repeat of the last target.
  logic [2:0] pick_base, pick;
  always_comb begin
    pick_base = lfsr_value;
    if (lfsr_value == 3'd0)      pick_base = 3'd1;
    else if (lfsr_value == 3'd7) pick_base = 3'd6;
    pick = pick_base;
    if (pick_base == target_reg)
      pick = (target_reg == 3'd6) ? 3'd1 : target_reg + 3'd1;
  end

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    seconds_next = seconds_reg;
    target_next  = target_reg;
    hit_req_next = 1'b0;
    hit_next     = 1'b0;
    miss_next    = 1'b0;
    start_ok     = 1'b0;
`ifdef DIFFICULTY_RAMP_EN
    window_next  = window_reg;
`endif
    case (state_reg)
      LOBBY, OVER: begin
        if (start_game) begin
          start_ok     = 1'b1;
          state_next   = GAP;
          phase_next   = '0;
          seconds_next = GAME_S;
`ifdef DIFFICULTY_RAMP_EN
          window_next  = TARGET_W;
`endif
        end
      end
      GAP: begin
        if (ms_tick) begin
          if (phase_reg == GAP_LAST) begin
            state_next  = SHOW;
            phase_next  = '0;
            target_next = pick;
          end else begin
            phase_next = phase_reg + CW'(1);
          end
        end
      end
      SHOW: begin
        // The match is registered once. This puts hit_pulse 4 clocks after the
        // pad change. A match seen in the timeout cycle is dropped.
        hit_req_next = match_edge;
        if (hit_req_reg) begin
          hit_next     = 1'b1;
          hit_req_next = 1'b0;
          state_next   = GAP;
          phase_next   = '0;
`ifdef DIFFICULTY_RAMP_EN
          window_next  = (window_reg >= FLOOR_W) ? window_reg - STEP_W : MIN_W;
`endif
        end else if (ms_tick && phase_reg == window - CW'(1)) begin
          miss_next    = 1'b1;
          hit_req_next = 1'b0;
          state_next   = GAP;
          phase_next   = '0;
        end else if (ms_tick) begin
          phase_next = phase_reg + CW'(1);
        end
      end
      default: state_next = LOBBY;
    endcase

    // Game clock. The step to zero overrides any transition. A hit decided in
    // the same cycle still produces its pulse.
    if ((state_reg == GAP || state_reg == SHOW) && sec_tick && seconds_reg != 6'd0) begin
      seconds_next = seconds_reg - 6'd1;
      if (seconds_reg == 6'd1) begin
        state_next   = OVER;
        phase_next   = '0;
        hit_req_next = 1'b0;
      end
    end

    if (start_ok) begin
      ms_cnt_next  = '0;
      sec_cnt_next = '0;
    end else begin
      ms_cnt_next  = ms_tick ? '0 : ms_cnt_reg + MSW'(1);
      sec_cnt_next = sec_cnt_reg;
      if (ms_tick) sec_cnt_next = (sec_cnt_reg == SEC_LAST) ? 10'd0 : sec_cnt_reg + 10'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg   <= LOBBY;
      ms_cnt_reg  <= '0;
      sec_cnt_reg <= '0;
      phase_reg   <= '0;
      seconds_reg <= GAME_S;
      target_reg  <= 3'd1;
      s1_reg      <= 3'd0;
      s2_reg      <= 3'd0;
      s3_reg      <= 3'd0;
      hit_req_reg <= 1'b0;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
`ifdef DIFFICULTY_RAMP_EN
      window_reg  <= TARGET_W;
`endif
    end else begin
      state_reg   <= state_next;
      ms_cnt_reg  <= ms_cnt_next;
      sec_cnt_reg <= sec_cnt_next;
      phase_reg   <= phase_next;
      seconds_reg <= seconds_next;
      target_reg  <= target_next;
      s1_reg      <= box_address;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      hit_req_reg <= hit_req_next;
      hit_reg     <= hit_next;
      miss_reg    <= miss_next;
`ifdef DIFFICULTY_RAMP_EN
      window_reg  <= window_next;
`endif
    end
  end

  always_comb begin
    case (state_reg)
      LOBBY:   mif_control_signal = 3'd0;
      SHOW:    mif_control_signal = target_reg;
      default: mif_control_signal = 3'd7;
    endcase
  end

  assign hit_pulse    = hit_reg;
  assign miss_pulse   = miss_reg;
  assign seconds_left = seconds_reg;
  assign game_over    = (state_reg == OVER);

endmodule
